// File: rtl/bk_subtractor_seq_pkg.sv
// Shared types and constants for the slice-serial Brent-Kung subtractor.
package bk_subtractor_seq_pkg;
  localparam int SLICE_DEF  = 16;
  localparam int WIDTH_DEF  = 64;
  localparam int NUM_SLICES = WIDTH_DEF / SLICE_DEF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/bk_slice_16.sv
// Combinational Brent-Kung adder slice with carry-in/carry-out (W must be a power of two, >= 2).
module bk_slice_16
  import bk_subtractor_seq_pkg::*;
#(
  parameter int W = SLICE_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W-1:0] g, p;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  always_comb begin
    logic [W-1:0] gp, pp;
    gp = g;
    pp = p;
    // Fold carry-in into bit 0 so every group generate becomes a carry.
    gp[0] = g[0] | (p[0] & cin_i);
    // Up-sweep tree.
    for (int d = 1; d < W; d = d * 2)
      for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
        gp[i] = gp[i] | (pp[i] & gp[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    // Down-sweep fills in the remaining prefixes.
    for (int d = W / 4; d >= 1; d = d / 2)
      for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
        gp[i] = gp[i] | (pp[i] & gp[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    sum_o  = p ^ {gp[W-2:0], cin_i};
    cout_o = gp[W-1];
  end
endmodule

// File: rtl/bk_subtractor_seq.sv
// Slice-serial subtractor: a - b - bin as a + ~b + ~bin, one SLICE per cycle through one BK slice.
module bk_subtractor_seq
  import bk_subtractor_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d, diff_q, diff_d;
  logic             carry_q, carry_d, bout_q, bout_d, ovf_q, ovf_d, ov_q, ov_d;
  logic [SLICE-1:0] a_sl, b_sl, sum_sl;
  logic             cout_sl, last;

  assign a_sl = a_q[idx_q*SLICE +: SLICE];
  assign b_sl = nb_q[idx_q*SLICE +: SLICE];
  assign last = (idx_q == IW'(NS - 1));

  bk_slice_16 #(.W(SLICE)) u_slice (
    .a_i   (a_sl),
    .b_i   (b_sl),
    .cin_i (carry_q),
    .sum_o (sum_sl),
    .cout_o(cout_sl)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    nb_d    = nb_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    ov_d    = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        nb_d    = ~b;
        carry_d = ~bin;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        diff_d[idx_q*SLICE +: SLICE] = sum_sl;
        carry_d = cout_sl;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          idx_d   = '0;
          state_d = DONE;
          bout_d  = ~cout_sl;
          // Operand MSBs differ exactly when a and ~b MSBs match.
          ovf_d   = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sum_sl[SLICE-1] != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        ov_d = 1'b1;
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      nb_q    <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
endmodule

// File: doc/bk_subtractor_seq.md
BK_SUBTRACTOR_SEQ -- requirements
Module: bk_subtractor_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand/result width in bits; legal values are multiples of SLICE.
REQ-002 SHALL have parameter SLICE, default 16, meaning bits processed per cycle.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a, b and bin are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port a, input, WIDTH bits: minuend, unsigned or two's complement.
REQ-008 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-009 SHALL have port bin, input, 1 bit: borrow-in.
REQ-010 SHALL have port out_valid, output, 1 bit: diff, bout and ovf are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port diff, output, WIDTH bits: a - b - bin modulo 2^WIDTH.
REQ-013 SHALL have port bout, output, 1 bit: unsigned borrow-out, 1 iff a < b + bin.
REQ-014 SHALL have port ovf, output, 1 bit: signed overflow, (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL assert in_ready only in IDLE; in_ready is 0 in RUN and DONE.
REQ-017 SHALL capture a, ~b and carry = ~bin into internal registers, and go to RUN with slice index 0, on a clock edge where in_valid && in_ready.
REQ-018 SHALL, in RUN, each cycle compute one SLICE-bit slice k as a_k + ~b_k + carry using a Brent-Kung prefix network, write it into diff bits [k*SLICE+SLICE-1 : k*SLICE], and register the slice carry-out for slice k+1.
REQ-019 SHALL process slices in order 0 to WIDTH/SLICE-1, then go to DONE; with defaults, RUN lasts exactly 4 cycles.
REQ-020 SHALL make out_valid rise in the cycle after the last slice completes: acceptance at edge N gives out_valid high from edge N+5 (defaults).
REQ-021 SHALL set bout = ~(final carry) and compute ovf from the final operands and diff.
REQ-022 SHALL hold diff, bout, ovf and out_valid stable in DONE until out_valid && out_ready, then go to IDLE and deassert out_valid.
REQ-023 SHALL ignore in_valid while not in IDLE; operands are not latched and no queueing occurs.
REQ-024 SHALL leave diff, bout and ovf holding their last values in IDLE and RUN; only out_valid qualifies them.
REQ-025 SHALL wrap the difference modulo 2^WIDTH, with no saturation.

Reset
REQ-026 SHALL, when rst is high at a clock edge, go to IDLE and clear slice index, carry, diff, bout, ovf and out_valid to 0; in_ready is 1 in the cycle after reset.
REQ-027 SHALL give rst priority over every handshake; rst during RUN or DONE discards the operation, and no out_valid is produced for it.

Structure
REQ-028 SHALL place in a shared package the FSM state enum, the SLICE default, and the slice-count constant WIDTH/SLICE.
REQ-029 SHALL use one combinational sub-module, bk_slice_16: SLICE-bit Brent-Kung adder with carry-in and carry-out, instantiated once and time-multiplexed across slices.
REQ-030 SHALL contain only the FSM, operand/result registers and slice mux/demux in the top level; RTL target 120-400 lines.

Verification
REQ-031 SHALL cover basic subtraction: a=100, b=58, bin=0 -> diff=42, bout=0, ovf=0, out_valid at edge N+5.
REQ-032 SHALL cover underflow wrap: a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0.
REQ-033 SHALL cover signed overflow with borrow-in: a=0x8000_0000_0000_0000, b=0, bin=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1.
REQ-034 SHALL cover cross-slice borrow: a=0x0000_0001_0000_0000, b=1, bin=0 -> diff=0x0000_0000_FFFF_FFFF, bout=0.
REQ-035 SHALL cover backpressure: out_ready held 0 for 10 cycles after out_valid -> result stable, in_ready=0 throughout, and a second in_valid pulse is ignored.
REQ-036 SHALL cover reset mid-RUN: rst pulsed at the 2nd RUN cycle -> out_valid never rises for that operation, outputs are 0, and in_ready=1 on the next cycle.
